// File: rtl/smem_bank_responder_pkg.sv
// Shared constants and grant-decode helpers for the shared-memory bank responder.
// The helper functions are sized to DEF_REQ_WIDTH, the requester count used across the CGRA.
package smem_pkg;

    localparam int DEF_REQ_WIDTH = 5;
    localparam int DEF_ADDR_W    = 8;
    localparam int DEF_DATA_W    = 32;
    localparam int DEF_RD_LAT    = 2;
    localparam int DEF_CNT_W     = 16;
    localparam int GNT_IDX_W     = $clog2(DEF_REQ_WIDTH);

    typedef logic [DEF_REQ_WIDTH-1:0] gnt_t;
    typedef logic [GNT_IDX_W-1:0]     gnt_idx_t;

    // True when exactly one grant bit is set.
    function automatic logic onehot_check(input gnt_t gnt);
        return (gnt != '0) && ((gnt & (gnt - gnt_t'(1))) == '0);
    endfunction

    // Binary index of a one-hot grant; result is meaningless for non-one-hot input.
    function automatic gnt_idx_t onehot2idx(input gnt_t gnt);
        gnt_idx_t idx;
        idx = '0;
        for (int i = 0; i < DEF_REQ_WIDTH; i++) begin
            if (gnt[i]) begin
                idx = idx | gnt_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

// File: rtl/smem_bank_responder_if.sv
// Request/response bundle between a bank's arbiter-side PEs and its responder.
// rsp_perr exists only when SMEM_PARITY_EN is defined.
interface smem_bank_if #(
    parameter int REQ_WIDTH = smem_pkg::DEF_REQ_WIDTH,
    parameter int ADDR_W    = smem_pkg::DEF_ADDR_W,
    parameter int DATA_W    = smem_pkg::DEF_DATA_W,
    parameter int CNT_W     = smem_pkg::DEF_CNT_W
);

    logic [REQ_WIDTH-1:0]        gnt;
    logic [REQ_WIDTH*ADDR_W-1:0] req_addr;
    logic [REQ_WIDTH*DATA_W-1:0] req_wdata;
    logic [REQ_WIDTH-1:0]        req_we;

    logic [REQ_WIDTH-1:0]        rsp_valid;
    logic                        rsp_we;
    logic [DATA_W-1:0]           rsp_rdata;
    logic [CNT_W-1:0]            rd_cnt;
    logic [CNT_W-1:0]            wr_cnt;
    logic                        err_gnt;
`ifdef SMEM_PARITY_EN
    logic                        rsp_perr;
`endif

    modport master (
        output gnt, req_addr, req_wdata, req_we,
        input  rsp_valid, rsp_we, rsp_rdata, rd_cnt, wr_cnt, err_gnt
`ifdef SMEM_PARITY_EN
        , input rsp_perr
`endif
    );

    modport slave (
        input  gnt, req_addr, req_wdata, req_we,
        output rsp_valid, rsp_we, rsp_rdata, rd_cnt, wr_cnt, err_gnt
`ifdef SMEM_PARITY_EN
        , output rsp_perr
`endif
    );

endinterface

// File: rtl/smem_bank_ram.sv
// Single-port write-first bank RAM with RD_LAT registered read stages.
// With SMEM_PARITY_EN defined each word carries an even-parity bit checked on read.
module smem_bank_ram #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              en_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] wdata_i,
    output logic [DATA_W-1:0] rdata_o
`ifdef SMEM_PARITY_EN
    , output logic            perr_o
`endif
);

`ifdef SMEM_PARITY_EN
    localparam int MEM_W = DATA_W + 1;
`else
    localparam int MEM_W = DATA_W;
`endif

    logic [MEM_W-1:0] mem_q [0:(1<<ADDR_W)-1];
    logic [MEM_W-1:0] rd_q  [RD_LAT];
    logic [MEM_W-1:0] wword;

`ifdef SMEM_PARITY_EN
    assign wword = {^wdata_i, wdata_i};
`else
    assign wword = wdata_i;
`endif

    // NOTE: the array has no reset; clearing it would turn the RAM into flops.
    // Sequential state uses <= so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (en_i && we_i) begin
            mem_q[addr_i] <= wword;
        end
    end

    // Write-first: a write returns the word being stored rather than the old contents.
    always_ff @(posedge clk) begin
        if (en_i) begin
            rd_q[0] <= we_i ? wword : mem_q[addr_i];
        end
        for (int k = 1; k < RD_LAT; k++) begin
            rd_q[k] <= rd_q[k-1];
        end
    end

    assign rdata_o = rd_q[RD_LAT-1][DATA_W-1:0];
`ifdef SMEM_PARITY_EN
    assign perr_o  = ^rd_q[RD_LAT-1];
`endif

endmodule

// File: rtl/smem_bank_responder.sv
// Target side of one shared-memory bank: grant decode/mux, RAM access, fixed-latency response.
// Optional feature macro: SMEM_PARITY_EN (parity-protected RAM words and rsp_perr output).
module smem_bank_responder
    import smem_pkg::*;
#(
    parameter int REQ_WIDTH = DEF_REQ_WIDTH,
    parameter int ADDR_W    = DEF_ADDR_W,
    parameter int DATA_W    = DEF_DATA_W,
    parameter int RD_LAT    = DEF_RD_LAT,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic       clk,
    input  logic       rst,
    smem_bank_if.slave bus
);

    typedef struct packed {
        logic                 valid;
        logic [REQ_WIDTH-1:0] gnt;
        logic                 we;
    } pipe_t;

    logic              gnt_onehot;
    logic              gnt_multi;
    gnt_idx_t          sel_idx;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;
    logic              sel_we;
    pipe_t             pipe_d0;
    pipe_t             pipe_q [RD_LAT];
    pipe_t             last;

    logic [DATA_W-1:0] ram_rdata;

    logic [REQ_WIDTH-1:0] rsp_valid_d, rsp_valid_q;
    logic                 rsp_we_d,    rsp_we_q;
    logic [DATA_W-1:0]    rsp_rdata_d, rsp_rdata_q;
    logic [CNT_W-1:0]     rd_cnt_d,    rd_cnt_q;
    logic [CNT_W-1:0]     wr_cnt_d,    wr_cnt_q;
    logic                 err_d,       err_q;
`ifdef SMEM_PARITY_EN
    logic                 ram_perr;
    logic                 rsp_perr_d,  rsp_perr_q;
`endif

    // NOTE: every signal gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        gnt_onehot    = onehot_check(bus.gnt);
        gnt_multi     = (bus.gnt != '0) && !gnt_onehot;
        sel_idx       = onehot2idx(bus.gnt);
        sel_addr      = bus.req_addr[sel_idx*ADDR_W +: ADDR_W];
        sel_wdata     = bus.req_wdata[sel_idx*DATA_W +: DATA_W];
        sel_we        = bus.req_we[sel_idx];
        pipe_d0       = '0;
        if (gnt_onehot) begin
            pipe_d0.valid = 1'b1;
            pipe_d0.gnt   = bus.gnt;
            pipe_d0.we    = sel_we;
        end
    end

    smem_bank_ram #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) u_ram (
        .clk     (clk),
        .en_i    (gnt_onehot),
        .we_i    (sel_we),
        .addr_i  (sel_addr),
        .wdata_i (sel_wdata),
        .rdata_o (ram_rdata)
`ifdef SMEM_PARITY_EN
        , .perr_o (ram_perr)
`endif
    );

    // Control pipeline runs alongside the RAM read stages so data and tag leave together.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < RD_LAT; k++) begin
                pipe_q[k] <= '0;
            end
        end else begin
            pipe_q[0] <= pipe_d0;
            for (int k = 1; k < RD_LAT; k++) begin
                pipe_q[k] <= pipe_q[k-1];
            end
        end
    end

    assign last = pipe_q[RD_LAT-1];

    always_comb begin
        rsp_valid_d = '0;
        rsp_we_d    = 1'b0;
        rsp_rdata_d = '0;
        rd_cnt_d    = rd_cnt_q;
        wr_cnt_d    = wr_cnt_q;
        err_d       = err_q | gnt_multi;
`ifdef SMEM_PARITY_EN
        rsp_perr_d  = 1'b0;
`endif
        if (last.valid) begin
            rsp_valid_d = last.gnt;
            rsp_we_d    = last.we;
            if (last.we) begin
                if (wr_cnt_q != '1) begin
                    wr_cnt_d = wr_cnt_q + CNT_W'(1);
                end
            end else begin
                rsp_rdata_d = ram_rdata;
`ifdef SMEM_PARITY_EN
                rsp_perr_d  = ram_perr;
`endif
                if (rd_cnt_q != '1) begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_valid_q <= '0;
            rsp_we_q    <= 1'b0;
            rsp_rdata_q <= '0;
            rd_cnt_q    <= '0;
            wr_cnt_q    <= '0;
            err_q       <= 1'b0;
`ifdef SMEM_PARITY_EN
            rsp_perr_q  <= 1'b0;
`endif
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_rdata_q <= rsp_rdata_d;
            rd_cnt_q    <= rd_cnt_d;
            wr_cnt_q    <= wr_cnt_d;
            err_q       <= err_d;
`ifdef SMEM_PARITY_EN
            rsp_perr_q  <= rsp_perr_d;
`endif
        end
    end

    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_rdata = rsp_rdata_q;
    assign bus.rd_cnt    = rd_cnt_q;
    assign bus.wr_cnt    = wr_cnt_q;
    assign bus.err_gnt   = err_q;
`ifdef SMEM_PARITY_EN
    assign bus.rsp_perr  = rsp_perr_q;
`endif

endmodule

// File: tb/tb_smem_bank_responder.sv
// Directed bench for smem_bank_responder with a scoreboard of expected responses.
// Counters are built 4 bits wide here so saturation is reachable in a short run.
module tb_smem_bank_responder;
    import smem_pkg::*;

    localparam int RQ  = DEF_REQ_WIDTH;
    localparam int AW  = DEF_ADDR_W;
    localparam int DW  = DEF_DATA_W;
    localparam int LAT = 2;
    localparam int CW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;

    smem_bank_if #(.REQ_WIDTH(RQ), .ADDR_W(AW), .DATA_W(DW), .CNT_W(CW)) bus ();

    smem_bank_responder #(
        .REQ_WIDTH (RQ),
        .ADDR_W    (AW),
        .DATA_W    (DW),
        .RD_LAT    (LAT),
        .CNT_W     (CW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        logic [RQ-1:0] gnt;
        logic          we;
        logic [DW-1:0] rdata;
        logic          perr;
    } exp_t;

    exp_t          sb_q[$];
    logic [DW-1:0] model_mem [0:(1<<AW)-1];
    int            cyc     = 0;
    int            n_pass  = 0;
    int            n_total = 0;
    logic [CW-1:0] exp_rd  = '0;
    logic [CW-1:0] exp_wr  = '0;
    logic          exp_err = 1'b0;
    logic          exp_perr_next = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    endtask

    // One clock: apply the model's view of the edge, then compare outputs 1 time unit later.
    task automatic tick();
        logic rst_at_edge;
        exp_t e;
        rst_at_edge = rst;
        @(posedge clk);
        cyc++;
        #1;
        if (rst_at_edge) begin
            sb_q.delete();
            exp_rd  = '0;
            exp_wr  = '0;
            exp_err = 1'b0;
        end
        if (sb_q.size() > 0 && sb_q[0].due == cyc) begin
            e = sb_q.pop_front();
            check("rsp_valid", 64'(bus.rsp_valid), 64'(e.gnt));
            check("rsp_we",    64'(bus.rsp_we),    64'(e.we));
            check("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
`ifdef SMEM_PARITY_EN
            check("rsp_perr",  64'(bus.rsp_perr),  64'(e.perr));
`endif
            if (e.we) begin
                if (exp_wr != '1) exp_wr++;
            end else begin
                if (exp_rd != '1) exp_rd++;
            end
        end else begin
            check("idle_valid", 64'(bus.rsp_valid), 64'(0));
            check("idle_we",    64'(bus.rsp_we),    64'(0));
            check("idle_rdata", 64'(bus.rsp_rdata), 64'(0));
        end
        check("rd_cnt",  64'(bus.rd_cnt),  64'(exp_rd));
        check("wr_cnt",  64'(bus.wr_cnt),  64'(exp_wr));
        check("err_gnt", 64'(bus.err_gnt), 64'(exp_err));
    endtask

    // Fill every PE slot with noise, then place the granted PE's request.
    task automatic scramble(input logic we);
        for (int i = 0; i < RQ; i++) begin
            bus.req_addr[i*AW +: AW]  = AW'($urandom);
            bus.req_wdata[i*DW +: DW] = $urandom;
            bus.req_we[i]             = ~we;
        end
    endtask

    task automatic access(input int pe, input logic we, input logic [AW-1:0] addr,
                          input logic [DW-1:0] wdata);
        exp_t e;
        scramble(we);
        bus.req_addr[pe*AW +: AW]  = addr;
        bus.req_wdata[pe*DW +: DW] = wdata;
        bus.req_we[pe]             = we;
        bus.gnt                    = '0;
        bus.gnt[pe]                = 1'b1;
        e.due  = cyc + 1 + LAT;
        e.gnt  = bus.gnt;
        e.we   = we;
        e.perr = exp_perr_next && !we;
        if (we) begin
            model_mem[addr] = wdata;
            e.rdata         = '0;
        end else begin
            e.rdata = model_mem[addr];
        end
        sb_q.push_back(e);
        tick();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            bus.gnt = '0;
            tick();
        end
    endtask

    task automatic do_reset(input int n);
        rst     = 1'b1;
        bus.gnt = '0;
        for (int i = 0; i < n; i++) tick();
        rst = 1'b0;
    endtask

    initial begin
        bus.gnt       = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
        bus.req_we    = '0;

        // Reset held three cycles, then a quiet stretch.
        do_reset(3);
        idle(10);

        // Write from PE0 then immediate read-back from PE2 (write-first).
        access(0, 1'b1, 8'h10, 32'hDEADBEEF);
        access(2, 1'b0, 8'h10, 32'h0);
        idle(LAT + 1);

        // Preload 0..4, then five back-to-back reads from five different PEs.
        do_reset(1);
        for (int i = 0; i < RQ; i++) access(RQ - 1 - i, 1'b1, AW'(i), $urandom);
        for (int i = 0; i < RQ; i++) access(i, 1'b0, AW'(i), 32'h0);
        idle(LAT + 1);
        check("rd_cnt_after_burst", 64'(bus.rd_cnt), 64'(5));

        // Multi-bit grant: no access, sticky error.
        scramble(1'b1);
        bus.gnt = 5'b00011;
        exp_err = 1'b1;
        tick();
        idle(LAT + 4);
        check("err_sticky", 64'(bus.err_gnt), 64'(1));

        // Reset one cycle after a read grant drops the response and its count.
        access(1, 1'b0, 8'h10, 32'h0);
        rst     = 1'b1;
        bus.gnt = '0;
        tick();
        rst = 1'b0;
        idle(LAT + 3);
        check("rd_cnt_after_drop", 64'(bus.rd_cnt), 64'(0));

        // Seventeen reads drive the 4-bit read counter into saturation.
        for (int i = 0; i < 17; i++) access(i % RQ, 1'b0, AW'(i % RQ), 32'h0);
        idle(LAT + 1);
        check("rd_cnt_saturated", 64'(bus.rd_cnt), 64'(15));

`ifdef SMEM_PARITY_EN
        // Corrupt the stored data bit 0 of a word and expect a parity error on read.
        access(0, 1'b1, 8'h20, 32'h1);
        idle(LAT + 1);
        dut.u_ram.mem_q[8'h20][0] = ~dut.u_ram.mem_q[8'h20][0];
        model_mem[8'h20] = 32'h0;
        exp_perr_next    = 1'b1;
        access(3, 1'b0, 8'h20, 32'h0);
        exp_perr_next    = 1'b0;
        idle(LAT + 1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
